greenflow_gate: RTL and testbench
=================================

GREENFLOW_GATE -- requirements
Module: greenflow_gate

Interface
REQ-001 The block SHALL have one parameter: DATA_W, default 16, width of all power and temperature buses.
REQ-002 The block SHALL have a port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have a port `rst_n`: input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have a port `llm_requested_kw`: input, DATA_W bits, unsigned power request from the AI planner (kW).
REQ-005 The block SHALL have a port `ai_data_valid`: input, 1 bit, high while the AI planner output is alive and trustworthy.
REQ-006 The block SHALL have a port `battery_temp_c`: input, DATA_W bits, unsigned battery temperature (deg C).
REQ-007 The block SHALL have a port `grid_limit_hard`: input, DATA_W bits, unsigned hard grid power ceiling (kW).
REQ-008 The block SHALL have a port `temp_limit_hard`: input, DATA_W bits, unsigned hard battery temperature ceiling (deg C).
REQ-009 The block SHALL have a port `safe_power_out`: output, DATA_W bits, registered gated power command (kW).
REQ-010 The block SHALL have a port `status_code`: output, 2 bits, registered gate status.

Function
REQ-011 All inputs SHALL be sampled on each rising `clk` edge; both outputs SHALL be registered and updated on that edge, one-cycle latency, no combinational input-to-output path.
REQ-012 Status encoding SHALL be: 2'b00 normal pass-through, 2'b01 grid clamp, 2'b10 thermal trip, 2'b11 AI fault.
REQ-013 Fault evaluation SHALL use fixed priority, highest first: AI fault, thermal trip, grid clamp, normal.
REQ-014 AI fault SHALL apply when `ai_data_valid` = 0: `safe_power_out` <= 0 and `status_code` <= 2'b11, regardless of all other inputs.
REQ-015 Thermal trip SHALL apply when `ai_data_valid` = 1 and `battery_temp_c` > `temp_limit_hard` (strict, unsigned): `safe_power_out` <= 0 and `status_code` <= 2'b10.
REQ-016 Temperature exactly equal to `temp_limit_hard` SHALL NOT trip.
REQ-017 Grid clamp SHALL apply when valid and no thermal trip and `llm_requested_kw` > `grid_limit_hard` (strict, unsigned): `safe_power_out` <= `grid_limit_hard` and `status_code` <= 2'b01.
REQ-018 A request exactly equal to `grid_limit_hard` SHALL pass as normal (code 00).
REQ-019 Normal operation SHALL apply otherwise: `safe_power_out` <= `llm_requested_kw` and `status_code` <= 2'b00.
REQ-020 `safe_power_out` SHALL never exceed `grid_limit_hard` as sampled in the same cycle.
REQ-021 The block SHALL hold no fault latching or hysteresis: each cycle's outputs depend only on the inputs sampled at that edge.
REQ-022 A `grid_limit_hard` of 0 SHALL force output 0 with code 01 for any nonzero valid request (code 00 for a zero request).
REQ-023 All comparisons SHALL be full DATA_W-bit unsigned; no truncation, saturation or sign extension.

Reset
REQ-024 While `rst_n` = 0 (asserted asynchronously, independent of `clk`): `safe_power_out` = 0, `status_code` = 2'b11 (fail-safe).
REQ-025 Reset assertion mid-operation SHALL force the reset values immediately, without waiting for a clock edge.
REQ-026 After `rst_n` deasserts, the first rising `clk` edge SHALL load outputs per REQ-013..REQ-019.

Verification
REQ-027 Normal: grid=200, tmax=45, temp=25, valid=1, req=150 -> next edge out=150, code 00.
REQ-028 Grid clamp: same limits, req=300 -> out=200, code 01; req=200 -> out=200, code 00.
REQ-029 Thermal: req=100, temp=50 -> out=0, code 10; temp=45 -> out=100, code 00.
REQ-030 AI fault: temp=30, valid=0, req=100 -> out=0, code 11; also with temp=50 and req=300 -> code 11 (priority).
REQ-031 Async reset: drive normal operation with out=150, pull `rst_n` low between clock edges -> out=0, code 11 immediately; release -> normal values after the next edge.
REQ-032 Latency: change req 150->120 just after an edge -> outputs unchanged until the following rising edge, then out=120.

Source files
------------

// File: rtl/greenflow_gate.sv
// Safety gate between an AI power planner and the plant: passes, clamps or zeroes the
// requested power each cycle by fixed priority, with a registered status code.
module greenflow_gate #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] llm_requested_kw,
    input  logic              ai_data_valid,
    input  logic [DATA_W-1:0] battery_temp_c,
    input  logic [DATA_W-1:0] grid_limit_hard,
    input  logic [DATA_W-1:0] temp_limit_hard,
    output logic [DATA_W-1:0] safe_power_out,
    output logic [1:0]        status_code
);

    typedef enum logic [1:0] {
        ST_NORMAL       = 2'b00,
        ST_GRID_CLAMP   = 2'b01,
        ST_THERMAL_TRIP = 2'b10,
        ST_AI_FAULT     = 2'b11
    } status_e;

    logic [DATA_W-1:0] power_d, power_q;
    status_e           status_d, status_q;

    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latch can be inferred.
        power_d  = '0;
        status_d = ST_AI_FAULT;
        if (!ai_data_valid) begin
            power_d  = '0;
            status_d = ST_AI_FAULT;
        end else if (battery_temp_c > temp_limit_hard) begin
            power_d  = '0;
            status_d = ST_THERMAL_TRIP;
        end else if (llm_requested_kw > grid_limit_hard) begin
            power_d  = grid_limit_hard;
            status_d = ST_GRID_CLAMP;
        end else begin
            power_d  = llm_requested_kw;
            status_d = ST_NORMAL;
        end
    end

    // Reset value is the fail-safe state: zero power, AI-fault code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            power_q  <= '0;
            status_q <= ST_AI_FAULT;
        end else begin
            // NOTE: non-blocking assignments for registered state avoid simulation races.
            power_q  <= power_d;
            status_q <= status_d;
        end
    end

    assign safe_power_out = power_q;
    assign status_code    = status_q;

endmodule

// File: tb/tb_greenflow_gate.sv
// Self-checking bench for greenflow_gate: expected outputs are queued when inputs are
// driven and compared one edge later against a reference model.
module tb_greenflow_gate;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] llm_requested_kw = '0;
    logic         ai_data_valid = 1'b0;
    logic [W-1:0] battery_temp_c = '0;
    logic [W-1:0] grid_limit_hard = '0;
    logic [W-1:0] temp_limit_hard = '0;
    logic [W-1:0] safe_power_out;
    logic [1:0]   status_code;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] out;
        logic [1:0]   code;
        string        name;
    } exp_t;

    exp_t sb[$];

    greenflow_gate #(.DATA_W(W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .llm_requested_kw (llm_requested_kw),
        .ai_data_valid    (ai_data_valid),
        .battery_temp_c   (battery_temp_c),
        .grid_limit_hard  (grid_limit_hard),
        .temp_limit_hard  (temp_limit_hard),
        .safe_power_out   (safe_power_out),
        .status_code      (status_code)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (actual=timeout required=finish)");
        $fatal(1, "watchdog expired");
    end

    // Reference model: pick the status by priority, then the power that status implies.
    function automatic exp_t model(input string name, input logic [W-1:0] req, input logic valid,
                                   input logic [W-1:0] temp, input logic [W-1:0] grid,
                                   input logic [W-1:0] tmax);
        exp_t e;
        e.name = name;
        if (valid !== 1'b1)   e.code = 2'b11;
        else if (temp > tmax) e.code = 2'b10;
        else if (req > grid)  e.code = 2'b01;
        else                  e.code = 2'b00;
        case (e.code)
            2'b00:   e.out = req;
            2'b01:   e.out = grid;
            default: e.out = '0;
        endcase
        return e;
    endfunction

    // Drive one vector on the falling edge, queue its expectation, land just past the next rising edge.
    task automatic drive(input string name, input logic [W-1:0] req, input logic valid,
                         input logic [W-1:0] temp, input logic [W-1:0] grid,
                         input logic [W-1:0] tmax);
        @(negedge clk);
        llm_requested_kw = req;
        ai_data_valid    = valid;
        battery_temp_c   = temp;
        grid_limit_hard  = grid;
        temp_limit_hard  = tmax;
        sb.push_back(model(name, req, valid, temp, grid, tmax));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive("reset_hold", 16'd150, 1'b1, 16'd25, 16'd200, 16'd45);
        sb.pop_front();
        checks++;
        if (safe_power_out !== 16'd0 || status_code !== 2'b11) begin
            errors++;
            $display("FAIL reset_state: out=%0d code=%b required out=0 code=11", safe_power_out, status_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(model("first_after_reset", 16'd150, 1'b1, 16'd25, 16'd200, 16'd45));
        @(posedge clk);
        #1;
        begin
            exp_t e = sb.pop_front();
            checks++;
            if (safe_power_out !== e.out || status_code !== e.code) begin
                errors++;
                $display("FAIL %s: out=%0d code=%b required out=%0d code=%b", e.name,
                         safe_power_out, status_code, e.out, e.code);
            end
        end
    endtask

    task automatic test_functions();
        exp_t vec[$];
        vec.push_back(model("normal", 150, 1, 25, 200, 45));
        vec.push_back(model("grid_clamp", 300, 1, 25, 200, 45));
        vec.push_back(model("grid_equal", 200, 1, 25, 200, 45));
        vec.push_back(model("thermal_trip", 100, 1, 50, 200, 45));
        vec.push_back(model("thermal_equal", 100, 1, 45, 200, 45));
        vec.push_back(model("ai_fault", 100, 0, 30, 200, 45));
        vec.push_back(model("ai_fault_priority", 300, 0, 50, 200, 45));
        vec.push_back(model("thermal_over_clamp", 300, 1, 46, 200, 45));
        vec.push_back(model("grid_zero_nonzero_req", 1, 1, 25, 0, 45));
        vec.push_back(model("grid_zero_zero_req", 0, 1, 25, 0, 45));
        vec.push_back(model("full_width_clamp", 16'hFFFF, 1, 25, 16'hFFFE, 45));
        vec.push_back(model("full_width_thermal", 10, 1, 16'hFFFF, 200, 16'hFFFE));
        vec.push_back(model("full_width_pass", 16'hFFFF, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF));
        vec.push_back(model("high_bit_compare", 16'h8000, 1, 0, 16'h7FFF, 0));
        // Expected values above are restated as literals in the table below and checked directly.
        begin
            logic [W-1:0] req_t[14]  = '{150, 300, 200, 100, 100, 100, 300, 300, 1, 0, 16'hFFFF, 10, 16'hFFFF, 16'h8000};
            logic         val_t[14]  = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
            logic [W-1:0] tmp_t[14]  = '{25, 25, 25, 50, 45, 30, 50, 46, 25, 25, 25, 16'hFFFF, 16'hFFFF, 0};
            logic [W-1:0] grd_t[14]  = '{200, 200, 200, 200, 200, 200, 200, 200, 0, 0, 16'hFFFE, 200, 16'hFFFF, 16'h7FFF};
            logic [W-1:0] tmx_t[14]  = '{45, 45, 45, 45, 45, 45, 45, 45, 45, 45, 45, 16'hFFFE, 16'hFFFF, 0};
            logic [W-1:0] out_t[14]  = '{150, 200, 200, 0, 100, 0, 0, 0, 0, 0, 16'hFFFE, 0, 16'hFFFF, 16'h7FFF};
            logic [1:0]   code_t[14] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
            for (int i = 0; i < 14; i++) begin
                exp_t e;
                drive(vec[i].name, req_t[i], val_t[i], tmp_t[i], grd_t[i], tmx_t[i]);
                e = sb.pop_front();
                checks++;
                if (safe_power_out !== out_t[i] || status_code !== code_t[i] ||
                    e.out !== out_t[i] || e.code !== code_t[i]) begin
                    errors++;
                    $display("FAIL %s: out=%0d code=%b required out=%0d code=%b", e.name,
                             safe_power_out, status_code, out_t[i], code_t[i]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        drive("pre_reset_normal", 150, 1, 25, 200, 45);
        e = sb.pop_front();
        checks++;
        if (safe_power_out !== e.out || status_code !== e.code) begin
            errors++;
            $display("FAIL %s: out=%0d code=%b required out=%0d code=%b", e.name,
                     safe_power_out, status_code, e.out, e.code);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (safe_power_out !== 16'd0 || status_code !== 2'b11) begin
            errors++;
            $display("FAIL async_reset_immediate: out=%0d code=%b required out=0 code=11",
                     safe_power_out, status_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(model("reset_release", 150, 1, 25, 200, 45));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (safe_power_out !== e.out || status_code !== e.code) begin
            errors++;
            $display("FAIL %s: out=%0d code=%b required out=%0d code=%b", e.name,
                     safe_power_out, status_code, e.out, e.code);
        end
    endtask

    task automatic test_latency();
        exp_t e;
        drive("latency_base", 150, 1, 25, 200, 45);
        e = sb.pop_front();
        llm_requested_kw = 16'd120;
        sb.push_back(model("latency_update", 120, 1, 25, 200, 45));
        @(negedge clk);
        checks++;
        if (safe_power_out !== 16'd150 || status_code !== 2'b00) begin
            errors++;
            $display("FAIL latency_hold: out=%0d code=%b required out=150 code=00",
                     safe_power_out, status_code);
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (safe_power_out !== e.out || status_code !== e.code) begin
            errors++;
            $display("FAIL %s: out=%0d code=%b required out=%0d code=%b", e.name,
                     safe_power_out, status_code, e.out, e.code);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            exp_t e;
            logic [W-1:0] req  = W'($urandom_range(0, 260));
            logic [W-1:0] grid = W'($urandom_range(0, 250));
            logic [W-1:0] temp = W'($urandom_range(20, 60));
            logic [W-1:0] tmax = W'($urandom_range(35, 55));
            logic         val  = ($urandom_range(0, 7) != 0);
            drive("random", req, val, temp, grid, tmax);
            e = sb.pop_front();
            checks++;
            if (safe_power_out !== e.out || status_code !== e.code || safe_power_out > grid) begin
                errors++;
                $display("FAIL random[%0d] req=%0d v=%b t=%0d g=%0d tm=%0d: out=%0d code=%b required out=%0d code=%b",
                         i, req, val, temp, grid, tmax, safe_power_out, status_code, e.out, e.code);
            end
        end
    endtask

    initial begin
        test_reset();
        test_functions();
        test_async_reset();
        test_latency();
        test_random();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
